// File: rtl/sd_pkg.sv
// Shared constants for the multi-block SD-card emulator: register map, command codes,
// FSM state encoding and STATUS bit positions.
package sd_pkg;

    localparam logic [31:0] REG_BASE   = 32'd0;
    localparam logic [31:0] REG_SECTOR = 32'd4;
    localparam logic [31:0] REG_COUNT  = 32'd8;
    localparam logic [31:0] REG_CTRL   = 32'd12;
    localparam logic [31:0] REG_STATUS = 32'd16;

    localparam logic [31:0] CMD_ABORT = 32'd0;
    localparam logic [31:0] CMD_READ  = 32'd2;
    localparam logic [31:0] CMD_WRITE = 32'd3;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_XFER_RD = 3'd1;
    localparam logic [2:0] ST_XFER_WR = 3'd2;
    localparam logic [2:0] ST_NEXT    = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

    function automatic logic is_xfer_cmd(input logic [31:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage

// File: rtl/sd_sector_ram.sv
// Single-port sector store: 1-cycle registered read, write-first on same-address access.
module sd_sector_ram #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are held inverted so an all-zero power-up image reads back as erased 0xFF.
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= ~wdata_i;
            rdata_q       <= wdata_i;
        end else if (re_i) begin
            rdata_q <= ~mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdcard_multiblock.sv
// Multi-block SD-card emulator: Avalon-MM register slave plus an engine that streams whole
// sectors between the internal sector RAM and the 8-bit FDD slave port.
module sdcard_multiblock
    import sd_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SECTOR_W   = 9,
    parameter int unsigned SECT_IDX_W = 12,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         sd_master_address,
    input  logic                sd_master_read,
    input  logic                sd_master_write,
    input  logic [31:0]         sd_master_writedata,
    output logic [31:0]         sd_master_readdata,
    output logic                sd_master_readdatavalid,
    output logic                sd_master_waitrequest,
    output logic [SECTOR_W-1:0] sd_slave_address,
    output logic                sd_slave_read,
    input  logic [DATA_W-1:0]   sd_slave_readdata,
    output logic                sd_slave_write,
    output logic [DATA_W-1:0]   sd_slave_writedata,
    output logic                done
);

    localparam int unsigned RAM_AW = SECT_IDX_W + SECTOR_W;

    logic [2:0]            state_q, state_d;
    logic                  dir_wr_q, dir_wr_d;
    logic [SECTOR_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [SECT_IDX_W-1:0] cur_sector_q, cur_sector_d;
    logic [CNT_W-1:0]      blocks_left_q, blocks_left_d;
    logic [31:0]           base_q, base_d;
    logic [SECT_IDX_W-1:0] sector_q, sector_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           ctrl_q, ctrl_d;
    logic                  err_q, err_d;
    logic                  done_sticky_q, done_sticky_d;
    logic                  done_q, done_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [SECTOR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  readdatavalid_q;

    logic                  busy;
    logic                  ctrl_wr;
    logic                  status_rd;
    logic                  range_bad;
    logic                  block_end;
    logic                  in_xfer;
    logic [SECT_IDX_W:0]   range_end;
    logic [SECT_IDX_W:0]   capacity;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  unused_base;

    assign busy      = (state_q != ST_IDLE);
    assign ctrl_wr   = sd_master_write && (sd_master_address == REG_CTRL);
    assign status_rd = sd_master_read && (sd_master_address == REG_STATUS);
    assign block_end = (byte_cnt_q == '1);
    assign in_xfer   = (state_q == ST_XFER_RD) || (state_q == ST_XFER_WR) ||
                       (state_q == ST_NEXT);

    // One extra bit so SECTOR+COUNT past the last sector cannot wrap back into range.
    assign capacity  = {1'b1, {SECT_IDX_W{1'b0}}};
    assign range_end = {1'b0, sector_q} + (SECT_IDX_W + 1)'(count_q);
    assign range_bad = (count_q == '0) || (range_end > capacity);

    always_comb begin
        state_d       = state_q;
        dir_wr_d      = dir_wr_q;
        byte_cnt_d    = byte_cnt_q;
        cur_sector_d  = cur_sector_q;
        blocks_left_d = blocks_left_q;
        base_d        = base_q;
        sector_d      = sector_q;
        count_d       = count_q;
        ctrl_d        = ctrl_q;
        err_d         = err_q;
        done_d        = 1'b0;

        if (sd_master_write && !busy) begin
            if (sd_master_address == REG_BASE)   base_d   = sd_master_writedata;
            if (sd_master_address == REG_SECTOR) sector_d = sd_master_writedata[SECT_IDX_W-1:0];
            if (sd_master_address == REG_COUNT)  count_d  = sd_master_writedata[CNT_W-1:0];
        end
        if (ctrl_wr) ctrl_d = sd_master_writedata;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && is_xfer_cmd(sd_master_writedata)) begin
                    if (range_bad) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d         = 1'b0;
                        dir_wr_d      = (sd_master_writedata == CMD_WRITE);
                        state_d       = (sd_master_writedata == CMD_WRITE) ? ST_XFER_WR
                                                                            : ST_XFER_RD;
                        cur_sector_d  = sector_q;
                        blocks_left_d = count_q;
                        byte_cnt_d    = '0;
                    end
                end
            end
            ST_XFER_RD, ST_XFER_WR: begin
                byte_cnt_d = byte_cnt_q + SECTOR_W'(1);
                if (block_end) begin
                    if (blocks_left_q == CNT_W'(1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d       = ST_NEXT;
                        cur_sector_d  = cur_sector_q + SECT_IDX_W'(1);
                        blocks_left_d = blocks_left_q - CNT_W'(1);
                    end
                end
            end
            ST_NEXT:   state_d = dir_wr_q ? ST_XFER_WR : ST_XFER_RD;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Commands arriving mid-transfer: ABORT wins over block sequencing, a second
        // READ/WRITE only flags the error.
        if (ctrl_wr && busy) begin
            if (sd_master_writedata == CMD_ABORT) begin
                if (in_xfer) begin
                    state_d = ST_FINISH;
                    err_d   = 1'b1;
                end
            end else if (is_xfer_cmd(sd_master_writedata)) begin
                err_d = 1'b1;
            end
        end

        if (state_d == ST_FINISH) done_d = 1'b1;

        done_sticky_d = done_sticky_q;
        if (status_rd) done_sticky_d = 1'b0;
        if (done_d)    done_sticky_d = 1'b1;

        rd_valid_d = (state_q == ST_XFER_RD);
        rd_addr_d  = (state_q == ST_XFER_RD) ? byte_cnt_q : '0;
    end

    always_comb begin
        readdata_d = '0;
        if (sd_master_read) begin
            case (sd_master_address)
                REG_BASE:   readdata_d = {31'd0, ~busy};
                REG_SECTOR: readdata_d = 32'(sector_q);
                REG_COUNT:  readdata_d = 32'(count_q);
                REG_CTRL:   readdata_d = ctrl_q;
                REG_STATUS: begin
                    readdata_d[STAT_BUSY] = busy;
                    readdata_d[STAT_DONE] = done_sticky_q;
                    readdata_d[STAT_ERR]  = err_q;
                end
                default:    readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            dir_wr_q        <= 1'b0;
            byte_cnt_q      <= '0;
            cur_sector_q    <= '0;
            blocks_left_q   <= '0;
            base_q          <= '0;
            sector_q        <= '0;
            count_q         <= '0;
            ctrl_q          <= '0;
            err_q           <= 1'b0;
            done_sticky_q   <= 1'b0;
            done_q          <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_addr_q       <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            dir_wr_q        <= dir_wr_d;
            byte_cnt_q      <= byte_cnt_d;
            cur_sector_q    <= cur_sector_d;
            blocks_left_q   <= blocks_left_d;
            base_q          <= base_d;
            sector_q        <= sector_d;
            count_q         <= count_d;
            ctrl_q          <= ctrl_d;
            err_q           <= err_d;
            done_sticky_q   <= done_sticky_d;
            done_q          <= done_d;
            rd_valid_q      <= rd_valid_d;
            rd_addr_q       <= rd_addr_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= sd_master_read;
        end
    end

    sd_sector_ram #(
        .ADDR_W (RAM_AW),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  ({cur_sector_q, byte_cnt_q}),
        .we_i    (state_q == ST_XFER_WR),
        .re_i    (state_q == ST_XFER_RD),
        .wdata_i (sd_slave_readdata),
        .rdata_o (ram_rdata)
    );

    // BASE is host bookkeeping only; the engine never consumes it.
    assign unused_base = ^base_q;

    assign sd_master_readdata      = readdata_q;
    assign sd_master_readdatavalid = readdatavalid_q;
    assign sd_master_waitrequest   = 1'b0;
    assign sd_slave_read           = (state_q == ST_XFER_WR);
    assign sd_slave_write          = rd_valid_q;
    assign sd_slave_address        = (state_q == ST_XFER_WR) ? byte_cnt_q : rd_addr_q;
    assign sd_slave_writedata      = rd_valid_q ? ram_rdata : '0;
    assign done                    = done_q;

endmodule

// File: tb/tb_sdcard_multiblock.sv
// Randomised self-checking bench for sdcard_multiblock against a sector-level memory model.
module tb_sdcard_multiblock;

    localparam int unsigned SECT_BYTES = 512;
    localparam logic [31:0] A_BASE = 32'd0, A_SECTOR = 32'd4, A_COUNT = 32'd8;
    localparam logic [31:0] A_CTRL = 32'd12, A_STATUS = 32'd16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sd_master_address = '0;
    logic        sd_master_read = 1'b0;
    logic        sd_master_write = 1'b0;
    logic [31:0] sd_master_writedata = '0;
    logic [31:0] sd_master_readdata;
    logic        sd_master_readdatavalid;
    logic        sd_master_waitrequest;
    logic [8:0]  sd_slave_address;
    logic        sd_slave_read;
    logic [7:0]  sd_slave_readdata;
    logic        sd_slave_write;
    logic [7:0]  sd_slave_writedata;
    logic        done;

    logic [7:0]  fdd_pat [SECT_BYTES];
    logic [7:0]  model_mem [int unsigned];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned wr_addr[$];
    int unsigned wr_cyc[$];
    logic [7:0]  wr_data[$];
    int unsigned rd_addr[$];

    always #5 clk = ~clk;

    assign sd_slave_readdata = fdd_pat[sd_slave_address];

    sdcard_multiblock dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .sd_master_address       (sd_master_address),
        .sd_master_read          (sd_master_read),
        .sd_master_write         (sd_master_write),
        .sd_master_writedata     (sd_master_writedata),
        .sd_master_readdata      (sd_master_readdata),
        .sd_master_readdatavalid (sd_master_readdatavalid),
        .sd_master_waitrequest   (sd_master_waitrequest),
        .sd_slave_address        (sd_slave_address),
        .sd_slave_read           (sd_slave_read),
        .sd_slave_readdata       (sd_slave_readdata),
        .sd_slave_write          (sd_slave_write),
        .sd_slave_writedata      (sd_slave_writedata),
        .done                    (done)
    );

    // Slave-side observer: records every strobe with its cycle number.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (sd_slave_write) begin
            wr_addr.push_back(32'(sd_slave_address));
            wr_data.push_back(sd_slave_writedata);
            wr_cyc.push_back(cyc);
        end
        if (sd_slave_read) rd_addr.push_back(32'(sd_slave_address));
        if (done) done_cnt++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not reach its end (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input int unsigned a);
        if (model_mem.exists(a)) return model_mem[a];
        return 8'hFF;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        sd_master_address   = a;
        sd_master_writedata = d;
        sd_master_write     = 1'b1;
        tick();
        sd_master_write     = 1'b0;
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        sd_master_address = a;
        sd_master_read    = 1'b1;
        tick();
        sd_master_read    = 1'b0;
        check("rdvalid", {31'd0, sd_master_readdatavalid}, 32'd1);
        d = sd_master_readdata;
    endtask

    task automatic expect_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        reg_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic start_cmd(input int unsigned s, input int unsigned c, input logic [31:0] cmd,
                             output int unsigned wb, output int unsigned rb,
                             output int unsigned db);
        reg_write(A_SECTOR, s);
        reg_write(A_COUNT, c);
        wb = wr_addr.size();
        rb = rd_addr.size();
        db = done_cnt;
        reg_write(A_CTRL, cmd);
    endtask

    task automatic wait_done(input string tag, input int unsigned db, input int unsigned budget);
        int unsigned n = 0;
        while (done_cnt == db && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done_cnt != db}, 32'd1);
        repeat (3) tick();
        check({tag, "_done_once"}, done_cnt - db, 32'd1);
    endtask

    task automatic check_rd_stream(input string tag, input int unsigned wb,
                                   input int unsigned s, input int unsigned c);
        int unsigned n = c * SECT_BYTES;
        int unsigned e0;
        check({tag, "_nstrobe"}, wr_addr.size() - wb, n);
        if (wr_addr.size() - wb == n) begin
            e0 = errors;
            for (int unsigned i = 0; i < n && errors == e0; i++) begin
                check({tag, "_addr"}, wr_addr[wb+i], i % SECT_BYTES);
                check({tag, "_data"}, 32'(wr_data[wb+i]),
                      32'(model_byte((s + i / SECT_BYTES) * SECT_BYTES + i % SECT_BYTES)));
                if (i > 0)
                    check({tag, "_spacing"}, wr_cyc[wb+i] - wr_cyc[wb+i-1],
                          (i % SECT_BYTES == 0) ? 32'd2 : 32'd1);
            end
        end
    endtask

    task automatic run_read(input string tag, input int unsigned s, input int unsigned c);
        int unsigned wb, rb, db;
        start_cmd(s, c, 32'd2, wb, rb, db);
        expect_reg({tag, "_mutex_busy"}, A_BASE, 32'd0);
        wait_done(tag, db, c * (SECT_BYTES + 1) + 20);
        check_rd_stream(tag, wb, s, c);
        check({tag, "_no_rdstrobe"}, rd_addr.size() - rb, 32'd0);
        expect_reg({tag, "_status"}, A_STATUS, 32'h2);
    endtask

    task automatic run_write(input string tag, input int unsigned s, input int unsigned c);
        int unsigned wb, rb, db, e0;
        int unsigned n = c * SECT_BYTES;
        start_cmd(s, c, 32'd3, wb, rb, db);
        wait_done(tag, db, c * (SECT_BYTES + 1) + 20);
        check({tag, "_nstrobe"}, rd_addr.size() - rb, n);
        check({tag, "_no_wrstrobe"}, wr_addr.size() - wb, 32'd0);
        if (rd_addr.size() - rb == n) begin
            e0 = errors;
            for (int unsigned i = 0; i < n && errors == e0; i++)
                check({tag, "_addr"}, rd_addr[rb+i], i % SECT_BYTES);
        end
        for (int unsigned k = 0; k < c; k++)
            for (int unsigned i = 0; i < SECT_BYTES; i++)
                model_mem[(s + k) * SECT_BYTES + i] = fdd_pat[i];
        expect_reg({tag, "_status"}, A_STATUS, 32'h2);
    endtask

    task automatic run_bad(input string tag, input int unsigned s, input int unsigned c);
        int unsigned wb, rb, db;
        logic [31:0] st;
        start_cmd(s, c, 32'd2, wb, rb, db);
        repeat (5) tick();
        check({tag, "_done"}, done_cnt - db, 32'd1);
        check({tag, "_no_strobe"}, (wr_addr.size() - wb) + (rd_addr.size() - rb), 32'd0);
        reg_read(A_STATUS, st);
        check({tag, "_err"}, {31'd0, st[2]}, 32'd1);
        check({tag, "_busy"}, {31'd0, st[0]}, 32'd0);
        expect_reg({tag, "_mutex"}, A_BASE, 32'd1);
    endtask

    initial begin
        int unsigned wb, rb, db, n, snap;
        int unsigned s, c;

        for (int i = 0; i < int'(SECT_BYTES); i++) fdd_pat[i] = 8'(i);
        repeat (3) tick();
        check("rst_wrstrobe", {31'd0, sd_slave_write}, 32'd0);
        check("rst_rdstrobe", {31'd0, sd_slave_read}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdvalid", {31'd0, sd_master_readdatavalid}, 32'd0);
        check("waitrequest", {31'd0, sd_master_waitrequest}, 32'd0);
        rst_n = 1'b1;
        tick();
        expect_reg("rst_mutex", A_BASE, 32'd1);
        expect_reg("rst_status", A_STATUS, 32'd0);
        expect_reg("rst_sector", A_SECTOR, 32'd0);
        expect_reg("rst_other", 32'd20, 32'd0);

        run_write("wr5", 5, 1);
        run_read("rd5", 5, 1);
        run_read("rd10x3", 10, 3);
        run_bad("cnt0", 7, 0);
        run_bad("ovr", 4095, 2);
        run_read("rd_last", 4095, 1);
        for (int i = 0; i < int'(SECT_BYTES); i++) fdd_pat[i] = 8'($urandom);
        run_write("wr_edge", 4094, 2);
        run_read("rd_edge", 4094, 2);

        for (int it = 0; it < 3; it++) begin
            s = $urandom_range(0, 4093);
            c = $urandom_range(1, 3);
            for (int i = 0; i < int'(SECT_BYTES); i++) fdd_pat[i] = 8'($urandom);
            run_write("wr_rand", s, c);
            run_read("rd_rand", s, c);
        end

        // Abort around byte 300 of the second block.
        start_cmd(20, 3, 32'd2, wb, rb, db);
        n = 0;
        while (wr_addr.size() - wb < SECT_BYTES + 300 && n < 3000) begin
            tick();
            n++;
        end
        check("abort_reach", wr_addr.size() - wb, SECT_BYTES + 300);
        reg_write(A_CTRL, 32'd0);
        repeat (3) tick();
        snap = wr_addr.size();
        repeat (6) tick();
        check("abort_stopped", wr_addr.size(), snap);
        check("abort_within2", {31'd0, (snap - wb) <= SECT_BYTES + 302}, 32'd1);
        check("abort_done", done_cnt - db, 32'd1);
        expect_reg("abort_status", A_STATUS, 32'h6);

        // Second READ while busy is ignored; SECTOR write while busy is ignored.
        start_cmd(5, 2, 32'd2, wb, rb, db);
        repeat (200) tick();
        reg_write(A_CTRL, 32'd2);
        reg_write(A_SECTOR, 32'd99);
        wait_done("busycmd", db, 2 * (SECT_BYTES + 1) + 20);
        check_rd_stream("busycmd", wb, 5, 2);
        expect_reg("busycmd_status", A_STATUS, 32'h6);
        expect_reg("busycmd_sticky_clr", A_STATUS, 32'h4);
        expect_reg("busycmd_sector", A_SECTOR, 32'd5);

        // Reset in the middle of a READ.
        start_cmd(7, 2, 32'd2, wb, rb, db);
        n = 0;
        while (wr_addr.size() - wb < 100 && n < 500) begin
            tick();
            n++;
        end
        check("rst_mid_reach", wr_addr.size() - wb, 32'd100);
        rst_n = 1'b0;
        tick();
        check("rst_mid_wr", {31'd0, sd_slave_write}, 32'd0);
        check("rst_mid_rd", {31'd0, sd_slave_read}, 32'd0);
        check("rst_mid_wdata", 32'(sd_slave_writedata), 32'd0);
        check("rst_mid_addr", 32'(sd_slave_address), 32'd0);
        rst_n = 1'b1;
        snap = wr_addr.size();
        repeat (5) tick();
        check("rst_mid_quiet", wr_addr.size(), snap);
        expect_reg("rst_mid_mutex", A_BASE, 32'd1);
        expect_reg("rst_mid_sector", A_SECTOR, 32'd0);
        expect_reg("rst_mid_count", A_COUNT, 32'd0);
        expect_reg("rst_mid_ctrl", A_CTRL, 32'd0);
        expect_reg("rst_mid_status", A_STATUS, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
